cache_fill_fsm: RTL and testbench

- Fill side of the cache interface: on a cache miss, fetches the 8-word (16-byte) block from main memory.
- Writes each returned word into the cache data array using word-select and data-array write strobes.
- Writes the tag array on the final word, so the line becomes valid only when complete.
- Sits between the cache (Miss, Write_Data_Array, Write_Tag_Array, Word_Num) and the multi-cycle pipelined main memory; one instance per cache (I and D).

---
 rtl/cache_fill_fsm_pkg.sv | 25 ++
 rtl/cache_fill_fsm_if.sv | 35 +++
 rtl/cache_fill_fsm_fill_counter.sv | 38 +++
 rtl/cache_fill_fsm.sv | 106 ++++++++++
 tb/tb_cache_fill_fsm.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache line fill engine.
//   - FSM state encoding
//   - block geometry (words per block, offset bits, bytes per word)
//   - counter width and the counter values the FSM compares against
package cache_fill_fsm_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WORDS      = 8;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned WORD_BYTES = 2;
  localparam int unsigned WORD_IDX_W = 3;
  localparam int unsigned CNT_W      = 4;

  // Counter values sized to the counter so compares stay width-clean.
  localparam logic [CNT_W-1:0] CNT_WORDS = 4'd8;
  localparam logic [CNT_W-1:0] CNT_LAST  = 4'd7;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StFill = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle of the cache-side and memory-side signals of the fill engine.
//   master: the fill FSM (consumes miss / memory response, drives writes / requests)
//   slave : the surrounding cache + main memory
interface cache_fill_fsm_if;
  import cache_fill_fsm_pkg::*;

  // Cache side
  logic                  miss_detected;
  logic [ADDR_W-1:0]     miss_address;
  logic                  fsm_busy;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [WORD_IDX_W-1:0] word_num;
  logic [DATA_W-1:0]     fill_data;
  logic                  fill_done;

  // Memory side
  logic [ADDR_W-1:0]     memory_address;
  logic                  memory_read_en;
  logic [DATA_W-1:0]     memory_data;
  logic                  memory_data_valid;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, write_data_array, write_tag_array, word_num, fill_data, fill_done,
           memory_address, memory_read_en
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, write_data_array, write_tag_array, word_num, fill_data, fill_done,
           memory_address, memory_read_en
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// 4-bit counter with synchronous clear and enable that saturates at the block size.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   clr_i : synchronous clear (wins over en_i)
//   en_i  : count enable
//   cnt_o : current count
module cache_fill_fsm_fill_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_WORDS)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache line fill engine. On a miss it issues eight back-to-back word reads to a
// pipelined main memory, writes each returned word into the data array, and writes
// the tag only with the final word so a line is never valid while partially filled.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : cache/memory signal bundle (master side)
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cache_fill_fsm_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;
  logic              cnt_clr, issue_en, recv_en;

  cache_fill_fsm_fill_counter u_issue_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (issue_en),
    .cnt_o (issue_cnt)
  );

  cache_fill_fsm_fill_counter u_recv_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (recv_en),
    .cnt_o (recv_cnt)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_clr  = 1'b0;
    issue_en = 1'b0;
    recv_en  = 1'b0;

    bus.fsm_busy         = 1'b0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.word_num         = '0;
    bus.fill_data        = '0;
    bus.memory_address   = '0;
    bus.memory_read_en   = 1'b0;
    bus.fill_done        = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.miss_detected) begin
          base_d  = {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          cnt_clr = 1'b1;
          state_d = StFill;
        end
      end

      StFill: begin
        bus.fsm_busy = 1'b1;

        // Issue side: one read per cycle until all words are requested. The offset is
        // spliced in rather than added so the tag/index bits can never change.
        if (issue_cnt != CNT_WORDS) begin
          bus.memory_read_en = 1'b1;
          bus.memory_address = {base_q[ADDR_W-1:OFF_W], issue_cnt[WORD_IDX_W-1:0], 1'b0};
          issue_en           = 1'b1;
        end

        // Receive side: responses come back in order, so only valids are counted.
        bus.write_data_array = bus.memory_data_valid;
        bus.fill_data        = bus.memory_data;
        bus.word_num         = recv_cnt[WORD_IDX_W-1:0];
        if (bus.memory_data_valid) begin
          recv_en = 1'b1;
          if (recv_cnt == CNT_LAST) begin
            bus.write_tag_array = 1'b1;
            state_d             = StDone;
          end
        end
      end

      StDone: begin
        bus.fill_done = 1'b1;
        state_d       = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic clk;
  logic rst;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Main memory contents (word addressed) and in-flight read queue.
  logic [15:0] mem [0:32767];

  typedef struct {
    int          due;
    logic [15:0] addr;
  } req_t;

  req_t q[$];

  localparam int MemLat = 4;

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  32'(bus.fsm_busy), 0);
    check_eq({tag, "_wda"},   32'(bus.write_data_array), 0);
    check_eq({tag, "_wta"},   32'(bus.write_tag_array), 0);
    check_eq({tag, "_wnum"},  32'(bus.word_num), 0);
    check_eq({tag, "_fdata"}, 32'(bus.fill_data), 0);
    check_eq({tag, "_maddr"}, 32'(bus.memory_address), 0);
    check_eq({tag, "_ren"},   32'(bus.memory_read_en), 0);
    check_eq({tag, "_done"},  32'(bus.fill_done), 0);
  endtask

  // One complete miss/fill transaction. Cycle 0 is the cycle the miss is presented;
  // requests are expected in cycles 1..8, each response MemLat cycles after its request
  // (plus any injected stalls), and fill_done the cycle after the eighth write.
  task automatic do_fill(input logic [15:0] addr, input int gap_after, input bit rand_gaps,
                         input bit hold_miss, input int abort_after);
    logic [15:0] base;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    req_t        r;
    int n_req, n_wr, n_tag, cyc, last_wr, hold, delivered;
    bit done_seen;
    base      = addr & 16'hFFF0;
    n_req     = 0;
    n_wr      = 0;
    n_tag     = 0;
    cyc       = 0;
    last_wr   = -1;
    hold      = 0;
    delivered = 0;
    done_seen = 1'b0;
    q.delete();

    @(posedge clk); #1;
    bus.miss_detected     = 1'b1;
    bus.miss_address      = addr;
    bus.memory_data_valid = 1'b0;
    #1;
    check_eq("miss_cycle_busy", 32'(bus.fsm_busy), 0);

    while (!done_seen && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (hold_miss) bus.miss_address = 16'($urandom);
      else           bus.miss_detected = 1'b0;

      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'($urandom);
      if (hold > 0) begin
        hold--;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        r = q.pop_front();
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = mem[r.addr[15:1]];
        delivered++;
        if (rand_gaps)                   hold = $urandom_range(0, 2);
        else if (delivered == gap_after) hold = 3;
      end
      #1;

      check_eq("read_en", 32'(bus.memory_read_en), 32'(cyc >= 1 && cyc <= 8));
      if (bus.memory_read_en) begin
        exp_addr = base + 16'(2 * n_req);
        check_eq("req_addr", 32'(bus.memory_address), 32'(exp_addr));
        q.push_back('{due: cyc + MemLat, addr: bus.memory_address});
        n_req++;
      end else begin
        check_eq("addr_idle", 32'(bus.memory_address), 0);
      end
      if (bus.write_tag_array) n_tag++;

      if (last_wr >= 0) begin
        check_eq("fill_done", 32'(bus.fill_done), 1);
        check_eq("done_busy", 32'(bus.fsm_busy), 0);
        check_eq("done_wda", 32'(bus.write_data_array), 0);
        check_eq("done_wta", 32'(bus.write_tag_array), 0);
        done_seen = 1'b1;
      end else begin
        check_eq("busy", 32'(bus.fsm_busy), 1);
        check_eq("fill_done_early", 32'(bus.fill_done), 0);
        check_eq("wda", 32'(bus.write_data_array), 32'(bus.memory_data_valid));
        if (bus.memory_data_valid) begin
          exp_data = mem[(base >> 1) + 16'(n_wr)];
          check_eq("word_num", 32'(bus.word_num), 32'(n_wr));
          check_eq("fill_data", 32'(bus.fill_data), 32'(exp_data));
          check_eq("wta", 32'(bus.write_tag_array), 32'(n_wr == 7));
          if (n_wr == 7) last_wr = cyc;
          n_wr++;
        end else begin
          check_eq("wta_novalid", 32'(bus.write_tag_array), 0);
        end
      end

      if (abort_after > 0 && n_wr == abort_after) begin
        @(posedge clk); #1;
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.memory_data_valid = 1'b0;
        @(posedge clk); #1;
        rst                   = 1'b0;
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'($urandom);
        #1;
        check_all_zero("after_rst");
        check_eq("abort_no_tag", 32'(n_tag), 0);
        q.delete();
        bus.memory_data_valid = 1'b0;
        return;
      end
    end

    if (!done_seen) check_eq("fill_timeout", 0, 1);
    check_eq("tag_count", 32'(n_tag), 1);
    check_eq("req_count", 32'(n_req), 8);

    @(posedge clk); #1;
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b0;
    #1;
    check_eq("post_busy", 32'(bus.fsm_busy), 0);
    check_eq("post_done", 32'(bus.fill_done), 0);
    @(posedge clk); #2;
    check_eq("post2_busy", 32'(bus.fsm_busy), 0);
    check_eq("post2_ren", 32'(bus.memory_read_en), 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      mem[(16'h1810 >> 1) + i] = 16'(i + 1);
      mem[(16'h1900 >> 1) + i] = 16'(16'h0100 + i);
    end

    rst                   = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data       = '0;
    bus.memory_data_valid = 1'b0;

    // Reset held two cycles, then stray valids while idle.
    @(posedge clk); @(posedge clk); #1;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hBEEF;
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check_all_zero("idle_valid");
    end
    bus.memory_data_valid = 1'b0;

    do_fill(16'h1816, 0, 1'b0, 1'b0, 0);
    do_fill(16'h1900, 0, 1'b0, 1'b0, 0);
    do_fill(16'($urandom), 0, 1'b0, 1'b1, 0);
    do_fill(16'h2A3C, 4, 1'b0, 1'b0, 0);
    do_fill(16'h1816, 0, 1'b0, 1'b0, 5);
    do_fill(16'h1816, 0, 1'b0, 1'b0, 0);

    for (int t = 0; t < 10; t++) begin
      do_fill(16'($urandom), 0, 1'b1, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
